// File: rtl/mips_regfile_32x32.sv
// 32x32 integer register file: one synchronous write port, two combinational read ports, R0 reads zero.
// Write lands on the rising edge, reads have zero latency, no backpressure; async active-low clear.
module mips_regfile_32x32 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rd_dat_i,
  input  logic        rw_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  output logic [31:0] rs_dat_o,
  output logic [31:0] rt_dat_o
);

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [31:0] wr_en;
  logic [31:0] rf_view [32];

  // Bit 0 of the decode is masked so writes to R0 are dropped.
  always_comb begin
    wr_en = '0;
    if (rw_i) begin
      wr_en = 32'd1 << rd_i;
    end
    wr_en[0] = 1'b0;
  end

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = wr_en[i] ? rd_dat_i : regs_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  assign rs_dat_o = rf_view[rs_i];
  assign rt_dat_o = rf_view[rt_i];

endmodule

// File: tb/tb_mips_regfile_32x32.sv
// Bench for mips_regfile_32x32: vector table, hand sequences for reset/ordering corners, random vs. array model.
module tb_mips_regfile_32x32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd;
  logic [31:0] rd_dat;
  logic        rw;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_dat;
  logic [31:0] rt_dat;

  int errors = 0;
  int checks = 0;

  mips_regfile_32x32 dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .rd_i     (rd),
    .rd_dat_i (rd_dat),
    .rw_i     (rw),
    .rs_i     (rs),
    .rt_i     (rt),
    .rs_dat_o (rs_dat),
    .rt_dat_o (rt_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
    logic        rw;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] mdl [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return i * 32'h01010101;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rd = a; rd_dat = d; rw = 1'b1;
    @(posedge clk);
    #1 rw = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] e;
    rst_n = 1'b0; rd = '0; rd_dat = '0; rw = 1'b0; rs = 5'd5; rt = 5'd31;
    #2;
    chk("reset_rs", rs_dat, 32'h0);
    chk("reset_rt", rt_dat, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async clear with no clock edge
    wr(5'd5, 32'hDEADBEEF);
    rs = 5'd5;
    #1 chk("prewrite_r5", rs_dat, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1 chk("async_clear_r5", rs_dat, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs = i[4:0]; rt = 5'(31 - i);
      #1;
      chk("post_reset_rs", rs_dat, 32'h0);
      chk("post_reset_rt", rt_dat, 32'h0);
    end

    // Vector table: write all, sweep, R0 protection, sweep again
    for (int i = 1; i < 32; i++) begin
      v.rd = i[4:0]; v.dat = pat(i); v.rw = 1'b1; v.rs = i[4:0]; v.rt = 5'd0;
      v.exp_rs = pat(i); v.exp_rt = 32'h0;
      vecs.push_back(v);
    end
    for (int i = 0; i < 32; i++) begin
      v.rd = 5'd0; v.dat = 32'h0; v.rw = 1'b0; v.rs = i[4:0]; v.rt = 5'(31 - i);
      v.exp_rs = pat(i); v.exp_rt = pat(31 - i);
      vecs.push_back(v);
    end
    v.rd = 5'd0; v.dat = 32'hFFFFFFFF; v.rw = 1'b1; v.rs = 5'd0; v.rt = 5'd0;
    v.exp_rs = 32'h0; v.exp_rt = 32'h0;
    vecs.push_back(v);
    for (int i = 0; i < 32; i++) begin
      v.rd = 5'd0; v.dat = 32'h0; v.rw = 1'b0; v.rs = 5'(31 - i); v.rt = i[4:0];
      v.exp_rs = pat(31 - i); v.exp_rt = pat(i);
      vecs.push_back(v);
    end
    foreach (vecs[k]) begin
      @(negedge clk);
      rd = vecs[k].rd; rd_dat = vecs[k].dat; rw = vecs[k].rw;
      rs = vecs[k].rs; rt = vecs[k].rt;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rs", k), rs_dat, vecs[k].exp_rs);
      chk($sformatf("vec%0d_rt", k), rt_dat, vecs[k].exp_rt);
    end

    // Write disable for three edges, then one enabled edge
    @(negedge clk);
    rd = 5'd7; rd_dat = 32'h12345678; rw = 1'b0; rs = 5'd7; rt = 5'd7;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1 chk("wr_disable_r7", rs_dat, 32'h07070707);
    end
    @(negedge clk);
    rw = 1'b1;
    #1 chk("wr_enable_before_edge", rs_dat, 32'h07070707);
    @(posedge clk);
    #1 chk("wr_enable_after_edge", rt_dat, 32'h12345678);
    rw = 1'b0;

    // Read-during-write returns old value until the edge
    wr(5'd9, 32'h11111111);
    @(negedge clk);
    rs = 5'd9; rt = 5'd9; rd = 5'd9; rd_dat = 32'h22222222; rw = 1'b1;
    #1;
    chk("rdw_before_rs", rs_dat, 32'h11111111);
    chk("rdw_before_rt", rt_dat, 32'h11111111);
    @(posedge clk);
    #1;
    chk("rdw_after_rs", rs_dat, 32'h22222222);
    chk("rdw_after_rt", rt_dat, 32'h22222222);
    rw = 1'b0;

    // Reset coincident with a write edge
    @(negedge clk);
    rd = 5'd3; rd_dat = 32'hAAAA5555; rw = 1'b1; rs = 5'd3; rt = 5'd9;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_vs_wr_r3", rs_dat, 32'h0);
    chk("rst_vs_wr_r9", rt_dat, 32'h0);
    rw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_vs_wr_lost", rs_dat, 32'h0);

    // Random traffic against an array model
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rd = 5'($urandom_range(0, 31)); rd_dat = $urandom; rw = 1'($urandom_range(0, 1));
      rs = 5'($urandom_range(0, 31)); rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      e = (rs == 5'd0) ? 32'h0 : mdl[rs];
      chk("rand_rs", rs_dat, e);
      e = (rt == 5'd0) ? 32'h0 : mdl[rt];
      chk("rand_rt", rt_dat, e);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1 chk("rand_async_clear", rs_dat, 32'h0);
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        #1 rst_n = 1'b1;
        rw = 1'b0;
      end
      @(posedge clk);
      if (rw && rd != 5'd0) mdl[rd] = rd_dat;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
